// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding,
// parity-mode constants, baud-divider calculation and the 3-sample vote.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int calc_bps_cnt(input int clk_fre, input int bps);
        return clk_fre / bps;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous output FIFO for the UART receiver (used when UART_RX_FIFO_EN
// is defined); a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_s;
    logic             push_ok_s;

    assign rd_valid  = (count_r != CW'(0));
    assign pop_s     = pop && rd_valid;
    assign push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_s);
    assign rd_data   = mem_r[rd_ptr_r];

    // Pointer, occupancy, storage and overrun-pulse update.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            overrun  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            overrun <= push && !push_ok_s;
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(push_ok_s) - CW'(pop_s);
        end
    end

endmodule

// File: rtl/uart_rx_ex.sv
// UART receiver with majority-vote sampling, optional parity and 1/2 stop bits.
// Define UART_RX_FIFO_EN to buffer words in a FIFO instead of a single holding register.
module uart_rx_ex
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 50_000_000,
    parameter int BPS        = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int BPS_CNT = calc_bps_cnt(CLK_FRE, BPS);
    localparam int MID     = BPS_CNT / 2;
    localparam int CW      = $clog2(BPS_CNT);

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY < PAR_NONE || PARITY > PAR_EVEN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx_ex: illegal parameter combination");
    end

    rx_state_t            state_r;
    logic                 rxd_meta_r;
    logic                 rxd_sync_r;
    logic                 rxd_prev_r;
    logic [CW-1:0]        clk_cnt_r;
    logic [3:0]           bit_cnt_r;
    logic [1:0]           samp_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_err_r;
    logic                 frm_err_r;
    logic                 done_r;
    logic                 sample_s;
    logic                 bit_end_s;
    logic                 maj_s;

    assign sample_s  = (clk_cnt_r == CW'(MID + 1));
    assign bit_end_s = (clk_cnt_r == CW'(BPS_CNT - 1));
    assign maj_s     = majority3(samp_r[0], samp_r[1], rxd_sync_r);

    // Synchroniser, bit timing and frame FSM; done_r marks a completed frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r    <= ST_IDLE;
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
            clk_cnt_r  <= '0;
            bit_cnt_r  <= 4'd0;
            samp_r     <= 2'b11;
            shift_r    <= '0;
            par_err_r  <= 1'b0;
            frm_err_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            rxd_meta_r <= uart_rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
            done_r     <= 1'b0;
            if (state_r != ST_IDLE) begin
                clk_cnt_r <= bit_end_s ? CW'(0) : clk_cnt_r + CW'(1);
                if (clk_cnt_r == CW'(MID - 1)) samp_r[0] <= rxd_sync_r;
                if (clk_cnt_r == CW'(MID))     samp_r[1] <= rxd_sync_r;
            end
            case (state_r)
                ST_IDLE: begin
                    clk_cnt_r <= '0;
                    bit_cnt_r <= 4'd0;
                    // Only a fresh 1->0 edge starts a frame, so a held-low break is ignored.
                    if (rxd_prev_r && !rxd_sync_r) begin
                        state_r   <= ST_START;
                        par_err_r <= 1'b0;
                        frm_err_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (sample_s && maj_s) begin
                        state_r <= ST_IDLE;
                    end else if (bit_end_s) begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sample_s) shift_r <= {maj_s, shift_r[DATA_BITS-1:1]};
                    if (bit_end_s) begin
                        if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
                            bit_cnt_r <= 4'd0;
                            state_r   <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample_s) begin
                        par_err_r <= (PARITY == PAR_ODD) ? ~(^shift_r ^ maj_s) : (^shift_r ^ maj_s);
                    end
                    if (bit_end_s) state_r <= ST_STOP;
                end
                ST_STOP: begin
                    if (sample_s) begin
                        if (!maj_s) frm_err_r <= 1'b1;
                        if (bit_cnt_r == 4'(STOP_BITS - 1)) begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                        end
                    end
                    if (bit_end_s) bit_cnt_r <= bit_cnt_r + 4'd1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [DATA_BITS+1:0] head_s;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .push      (done_r),
        .push_data ({par_err_r, frm_err_r, shift_r}),
        .pop       (rx_valid && rx_ready),
        .rd_data   (head_s),
        .rd_valid  (rx_valid),
        .overrun   (rx_overrun)
    );

    assign rx_data       = head_s[DATA_BITS-1:0];
    assign rx_frame_err  = head_s[DATA_BITS];
    assign rx_parity_err = head_s[DATA_BITS+1];
`else
    // Single holding register: a word completing while one is still pending is dropped.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (done_r) begin
                if (!rx_valid || rx_ready) begin
                    rx_data       <= shift_r;
                    rx_parity_err <= par_err_r;
                    rx_frame_err  <= frm_err_r;
                    rx_valid      <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ex.sv
// Randomised self-checking bench for uart_rx_ex: a default instance and an
// even-parity / two-stop-bit instance, checked against a frame-level word queue.
module tb_uart_rx_ex;

    localparam int BC0 = 50_000_000 / 115200;
    localparam int BC1 = 50_000_000 / 1_000_000;
`ifdef UART_RX_FIFO_EN
    localparam int CAP0 = 4;
`else
    localparam int CAP0 = 1;
`endif

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rxd0 = 1'b1, rxd1 = 1'b1;
    logic       rdy0 = 1'b1, rdy1 = 1'b1;
    logic [7:0] data0, data1;
    logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;

    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   ovr_seen0 = 0, ovr_exp0 = 0, ovr_seen1 = 0;
    int   valid_cyc0 = 0, xfer0 = 0, xfer1 = 0;

    uart_rx_ex dut0 (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .uart_rxd      (rxd0),
        .rx_data       (data0),
        .rx_valid      (v0),
        .rx_ready      (rdy0),
        .rx_parity_err (pe0),
        .rx_frame_err  (fe0),
        .rx_overrun    (ov0)
    );

    uart_rx_ex #(
        .CLK_FRE   (50_000_000),
        .BPS       (1_000_000),
        .DATA_BITS (8),
        .PARITY    (2),
        .STOP_BITS (2)
    ) dut1 (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .uart_rxd      (rxd1),
        .rx_data       (data1),
        .rx_valid      (v1),
        .rx_ready      (rdy1),
        .rx_parity_err (pe1),
        .rx_frame_err  (fe1),
        .rx_overrun    (ov1)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rxd0 = v;
        else            rxd1 = v;
    endtask

    // Serial line driver: start bit, 8 data bits LSB first, optional parity, stop bits.
    task automatic tx(input int which, input logic [7:0] d, input bit has_par, input logic pbit,
                      input int nstop, input logic [1:0] stops, input logic end_level);
        int   bc;
        logic b[$];
        bc = (which == 0) ? BC0 : BC1;
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (has_par) b.push_back(pbit);
        for (int i = 0; i < nstop; i++) b.push_back(stops[i]);
        foreach (b[i]) begin
            drive(which, b[i]);
            wait_cyc(bc);
        end
        drive(which, end_level);
    endtask

    // Reference for the default instance: buffer of CAP0 words while the consumer stalls.
    task automatic expect0(input logic [7:0] d, input logic fe);
        exp_t e;
        if (rdy0 == 1'b0 && q0.size() >= CAP0) begin
            ovr_exp0++;
        end else begin
            e.d = d; e.pe = 1'b0; e.fe = fe;
            q0.push_back(e);
        end
    endtask

    task automatic frame1(input logic [7:0] d, input logic pbit, input logic [1:0] stops);
        exp_t e;
        e.d  = d;
        e.pe = ((^d) ^ pbit) != 1'b0;
        e.fe = !(stops[0] && stops[1]);
        q1.push_back(e);
        tx(1, d, 1'b1, pbit, 2, stops, 1'b1);
        wait_cyc(BC1);
    endtask

    // Output monitor: every handshake must match the head of the expected queue.
    always @(negedge sys_clk) begin : mon
        exp_t e;
        if (!sys_rst) begin
            if (v0) valid_cyc0++;
            if (ov0) ovr_seen0++;
            if (ov1) ovr_seen1++;
            if (v0 && rdy0) begin
                xfer0++;
                check_eq("dut0_word_expected", 32'(q0.size() > 0), 32'd1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    check_eq("dut0_rx_data", 32'(data0), 32'(e.d));
                    check_eq("dut0_parity_err", 32'(pe0), 32'(e.pe));
                    check_eq("dut0_frame_err", 32'(fe0), 32'(e.fe));
                end
            end
            if (v1 && rdy1) begin
                xfer1++;
                check_eq("dut1_word_expected", 32'(q1.size() > 0), 32'd1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    check_eq("dut1_rx_data", 32'(data1), 32'(e.d));
                    check_eq("dut1_parity_err", 32'(pe1), 32'(e.pe));
                    check_eq("dut1_frame_err", 32'(fe1), 32'(e.fe));
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge sys_clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        int vc, xf, os;
        logic [7:0] rd;

        wait_cyc(4);
        check_eq("reset_outputs0", {ov0, fe0, pe0, v0, data0}, 32'd0);
        check_eq("reset_outputs1", {ov1, fe1, pe1, v1, data1}, 32'd0);
        sys_rst = 1'b0;
        wait_cyc(10);

        // Default frame 0xA5 with consumer ready: one single-cycle valid.
        vc = valid_cyc0; xf = xfer0;
        expect0(8'hA5, 1'b0);
        tx(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11, 1'b1);
        wait_cyc(BC0);
        check_eq("a5_valid_cycles", 32'(valid_cyc0 - vc), 32'd1);
        check_eq("a5_transfers", 32'(xfer0 - xf), 32'd1);

        // 60-clock glitch must not produce a word; a following frame proves IDLE.
        vc = valid_cyc0;
        rxd0 = 1'b0; wait_cyc(60); rxd0 = 1'b1;
        wait_cyc(3 * BC0);
        check_eq("glitch_no_valid", 32'(valid_cyc0 - vc), 32'd0);
        xf = xfer0;
        expect0(8'h3C, 1'b0);
        tx(0, 8'h3C, 1'b0, 1'b0, 1, 2'b11, 1'b1);
        wait_cyc(BC0);
        check_eq("after_glitch_transfers", 32'(xfer0 - xf), 32'd1);

        // Stop bit 0 then a 5-bit break: one errored word, no second word.
        xf = xfer0;
        expect0(8'h00, 1'b1);
        tx(0, 8'h00, 1'b0, 1'b0, 1, 2'b00, 1'b0);
        wait_cyc(5 * BC0);
        rxd0 = 1'b1;
        wait_cyc(2 * BC0);
        check_eq("break_transfers", 32'(xfer0 - xf), 32'd1);
        check_eq("break_queue_empty", 32'(q0.size()), 32'd0);

        // Stalled consumer with three frames.
        rdy0 = 1'b0; os = ovr_seen0; ovr_exp0 = 0;
        expect0(8'h11, 1'b0); tx(0, 8'h11, 1'b0, 1'b0, 1, 2'b11, 1'b1); wait_cyc(BC0 / 4);
        expect0(8'h22, 1'b0); tx(0, 8'h22, 1'b0, 1'b0, 1, 2'b11, 1'b1); wait_cyc(BC0 / 4);
        expect0(8'h33, 1'b0); tx(0, 8'h33, 1'b0, 1'b0, 1, 2'b11, 1'b1);
        wait_cyc(BC0);
        check_eq("stall_overrun_pulses", 32'(ovr_seen0 - os), 32'(ovr_exp0));
        check_eq("stall_valid", 32'(v0), 32'd1);
        check_eq("stall_head_data", 32'(data0), 32'h11);
        rdy0 = 1'b1;
        wait_cyc(10);
        check_eq("stall_drained", 32'(q0.size()), 32'd0);

        // Reset during data bit 4 while a word is pending.
        rdy0 = 1'b0;
        expect0(8'h66, 1'b0);
        tx(0, 8'h66, 1'b0, 1'b0, 1, 2'b11, 1'b1);
        wait_cyc(20);
        check_eq("pre_reset_valid", 32'(v0), 32'd1);
        fork
            tx(0, 8'hFF, 1'b0, 1'b0, 1, 2'b11, 1'b1);
            begin
                wait_cyc(5 * BC0 + BC0 / 2);
                sys_rst = 1'b1;
                q0.delete();
                wait_cyc(1);
                check_eq("midframe_reset_outputs", {ov0, fe0, pe0, v0, data0}, 32'd0);
                sys_rst = 1'b0;
            end
        join
        rdy0 = 1'b1;
        wait_cyc(BC0);
        xf = xfer0;
        expect0(8'h5A, 1'b0);
        tx(0, 8'h5A, 1'b0, 1'b0, 1, 2'b11, 1'b1);
        wait_cyc(BC0);
        check_eq("post_reset_transfers", 32'(xfer0 - xf), 32'd1);

        // Random words on the default instance.
        for (int i = 0; i < 2; i++) begin
            rd = 8'($urandom);
            expect0(rd, 1'b0);
            tx(0, rd, 1'b0, 1'b0, 1, 2'b11, 1'b1);
            wait_cyc(BC0);
        end
        check_eq("dut0_queue_empty", 32'(q0.size()), 32'd0);

        // Even parity instance: directed 0x03 with parity 1, then random frames.
        xf = xfer1;
        frame1(8'h03, 1'b1, 2'b11);
        for (int i = 0; i < 12; i++) begin
            frame1(8'($urandom), 1'($urandom_range(0, 1)),
                   {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
        end
        wait_cyc(2 * BC1);
        check_eq("dut1_transfers", 32'(xfer1 - xf), 32'd13);
        check_eq("dut1_queue_empty", 32'(q1.size()), 32'd0);
        check_eq("dut1_no_overrun", 32'(ovr_seen1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ex.md
UART_RX_EX -- requirements
Module: uart_rx_ex

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BPS, default 115200, meaning baud rate; BPS_CNT = CLK_FRE/BPS.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries, power of two; used only with UART_RX_FIFO_EN.
REQ-007 SHALL have port sys_clk  input  1  system clock; all logic on rising edge.
REQ-008 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data  output  DATA_BITS  received word, LSB first on line.
REQ-011 SHALL have port rx_valid  output  1  rx_data and error flags valid.
REQ-012 SHALL have port rx_ready  input  1  consumer accepts the word.
REQ-013 SHALL have port rx_parity_err  output  1  parity mismatch for the presented word.
REQ-014 SHALL have port rx_frame_err  output  1  a stop bit sampled 0 for the presented word.
REQ-015 SHALL have port rx_overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-016 SHALL pass uart_rxd through a 2-flop synchroniser; start is detected on a synchronised 1->0 transition in IDLE only.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-018 SHALL sample each bit by majority of three samples at clk_cnt = BPS_CNT/2-1, BPS_CNT/2, BPS_CNT/2+1.
REQ-019 SHALL return START->IDLE with no output when the start-bit majority is 1 (false start).
REQ-020 SHALL shift DATA_BITS samples LSB first, then compute parity over the data bits (odd: XOR of data and parity = 1; even: = 0).
REQ-021 SHALL flag rx_frame_err if any of the STOP_BITS stop samples is 0, and still deliver the word.
REQ-022 SHALL return to IDLE immediately after the last stop-bit mid-sample, not at bit end.
REQ-023 SHALL push the word plus both error flags in the cycle after the last stop-bit mid-sample, so rx_valid rises one cycle later.
REQ-024 SHALL hold rx_data, rx_parity_err, rx_frame_err stable while rx_valid=1 and rx_ready=0; transfer occurs on a cycle with both high.
REQ-025 SHALL not start a new frame from a line held low after a frame; a fresh 1->0 edge is required (break handling).
REQ-026 SHALL keep rx_parity_err=0 when PARITY=0.

Reset
REQ-027 SHALL, on sys_rst=1, abort any frame, force IDLE, zero counters, set synchroniser flops to 1, and drive rx_data=0, rx_valid=0, both error flags 0, rx_overrun=0 in the next cycle.

Configuration
REQ-028 SHALL, with UART_RX_FIFO_EN defined, buffer words in a FIFO_DEPTH-entry FIFO; rx_overrun pulses only when a push meets a full FIFO without a simultaneous pop.
REQ-029 SHALL, with UART_RX_FIFO_EN defined, accept push and pop in the same cycle when full, with no overrun.
REQ-030 SHALL, without UART_RX_FIFO_EN, use one holding register; a frame completing while rx_valid=1 and rx_ready=0 is dropped and rx_overrun pulses; a frame completing in the same cycle as a transfer is accepted.

Structure
REQ-031 SHALL place the FSM state typedef, parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and BPS_CNT calculation in shared package uart_pkg.
REQ-032 SHALL implement the buffer as sub-module uart_rx_fifo, instantiated only under UART_RX_FIFO_EN.

Verification
REQ-033 SHALL cover: defaults, frame 0xA5, rx_ready=1 -> rx_valid for one cycle, rx_data=0xA5, no error flags.
REQ-034 SHALL cover: PARITY=2, frame 0x03 with parity bit 1 -> rx_data=0x03, rx_parity_err=1.
REQ-035 SHALL cover: 60-clock low glitch on idle line -> no rx_valid, FSM back in IDLE.
REQ-036 SHALL cover: stop bit forced 0 on frame 0x00, line then held low 5 bit times -> one word 0x00 with rx_frame_err=1, no second word.
REQ-037 SHALL cover: rx_ready=0, three frames 0x11,0x22,0x33 -> without macro rx_data stays 0x11 and two rx_overrun pulses; with macro (FIFO_DEPTH=4) no overrun, words read in order.
REQ-038 SHALL cover: sys_rst asserted during data bit 4 -> all outputs 0 next cycle, following clean frame 0x5A received correctly.
